// File: rtl/snn_aer_pkg.sv
// snn_aer_pkg: shared definitions for the AER transmit path.
package snn_aer_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // Link-side word layout is {ev_ts, ev_id}: timestamp in the upper bits.
    localparam bit AER_TS_HIGH = 1'b1;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lowest_set_index.sv
// lowest_set_index: combinational priority encoder giving the lowest set bit,
// plus flags for "exactly one bit set" and "any bit set".
module lowest_set_index
    import snn_aer_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    vec,
    output logic [ID_W-1:0] index,
    output logic            one_hot,
    output logic            any
);

    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vec[i]) index = ID_W'(i);
    end

    assign any     = |vec;
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign one_hot = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: captures the spike vector on each timestep strobe and
// serializes set bits as (neuron id, timestep) events on a valid/ready stream.
module spike_aer_encoder
    import snn_aer_pkg::*;
#(
    parameter int N    = 4,
    parameter int TS_W = 8,
    parameter int ID_W = id_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N-1:0]    spikes_in,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [ID_W-1:0] ev_id,
    output logic [TS_W-1:0] ev_ts,
    output logic            ev_last,
    output logic            busy,
    output logic            overflow,
    input  logic            clear_overflow,
    output logic [TS_W-1:0] ts_count
);

    logic [N-1:0]    pending, pending_next;
    logic [TS_W-1:0] frame_ts, frame_ts_next, ts_cnt;
    logic [ID_W-1:0] low_id;
    logic            one_hot, any, fire, capture, drop, overflow_next;
    state_t          state;

    lowest_set_index #(.N(N), .ID_W(ID_W)) u_lsi (
        .vec     (pending),
        .index   (low_id),
        .one_hot (one_hot),
        .any     (any)
    );

    always_comb begin
        state         = any ? S_SCAN : S_IDLE;
        fire          = any & ev_ready;
        // A new frame may enter only when the current one is finished this cycle.
        capture       = enable & ((state == S_IDLE) | (fire & one_hot));
        drop          = enable & ~capture;
        pending_next  = fire ? (pending & ~(N'(1) << low_id)) : pending;
        frame_ts_next = frame_ts;
        overflow_next = drop | (overflow & ~clear_overflow);
        if (capture) begin
            pending_next  = spikes_in;
            frame_ts_next = ts_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            frame_ts <= '0;
            ts_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_next;
            frame_ts <= frame_ts_next;
            ts_cnt   <= ts_cnt + TS_W'(enable);
            overflow <= overflow_next;
        end
    end

    assign ev_valid = any;
    assign busy     = any;
    assign ev_id    = low_id;
    assign ev_last  = one_hot;
    assign ev_ts    = frame_ts;
    assign ts_count = ts_cnt;

endmodule
